// File: rtl/grostl_add_constant_stream_if.sv
// Stream bundle for the Grostl AddRoundConstant stage.
// Carries the upstream beat (s_*) and the downstream beat (m_*) of one stage.
//   slave  : stage side  (consumes s_*, produces m_*, consumes m_ready)
//   master : environment (produces s_*, consumes m_*, produces m_ready)
// Parameters: LANES (64-bit columns per beat), RNDW (round-number width).
`timescale 1ns/1ps
interface grostl_add_constant_stream_if #(
  parameter int unsigned LANES = 1,
  parameter int unsigned RNDW  = 4
);
  localparam int unsigned DW = LANES * 64;

  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic            s_pq;
  logic [RNDW-1:0] s_rnd;

  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic            m_pq;
  logic [RNDW-1:0] m_rnd;
  logic            m_first;
  logic            m_last;

  modport slave (
    input  s_valid, s_data, s_pq, s_rnd, m_ready,
    output s_ready, m_valid, m_data, m_pq, m_rnd, m_first, m_last
  );

  modport master (
    output s_valid, s_data, s_pq, s_rnd, m_ready,
    input  s_ready, m_valid, m_data, m_pq, m_rnd, m_first, m_last
  );
endinterface

// File: rtl/grostl_add_constant_stream.sv
// Column-serial AddRoundConstant stage for the Grostl P and Q permutations.
// A state of NCOLS 64-bit columns streams through as NCOLS/LANES beats; the
// column index is tracked internally and first/last beats are tagged.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   bus.slave  s_valid/s_ready/s_data/s_pq/s_rnd in,
//              m_valid/m_ready/m_data/m_pq/m_rnd/m_first/m_last out
// Optional feature macro: GROSTL_AC_SKID_EN
//   undefined : s_ready = !m_valid || m_ready (combinational)
//   defined   : 1-entry skid register, s_ready registered (skid empty)
`timescale 1ns/1ps
module grostl_add_constant_stream #(
  parameter int unsigned NCOLS     = 8,
  parameter int unsigned LANES     = 1,
  parameter int unsigned RNDW      = 4,
  parameter int unsigned Q_COL_OFS = 6
) (
  input logic clk,
  input logic rst,
  grostl_add_constant_stream_if.slave bus
);

  localparam int unsigned DW    = LANES * 64;
  localparam int unsigned COLW  = $clog2(NCOLS);
  localparam int unsigned BEATS = NCOLS / LANES;
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BCW-1:0]  BCNT_LAST = BCW'(BEATS - 1);
  // NCOLS is a power of two, so truncation is the mod-NCOLS reduction.
  localparam logic [COLW-1:0] QOFS      = COLW'(Q_COL_OFS);

  typedef struct packed {
    logic [DW-1:0]   data;
    logic            pq;
    logic [RNDW-1:0] rnd;
    logic            first;
    logic            last;
  } beat_t;

  // Round-constant byte: column nibble in the high half, round nibble low.
  function automatic logic [7:0] ac_byte(input logic [COLW-1:0] col,
                                         input logic [RNDW-1:0] rnd);
    return {4'(col), 4'(rnd)};
  endfunction

  // One column of AddRoundConstant; byte 0 sits in bits [63:56].
  function automatic logic [63:0] ac_column(input logic [63:0]     c,
                                            input logic [COLW-1:0] col,
                                            input logic            pq,
                                            input logic [RNDW-1:0] rnd);
    logic [63:0] r;
    if (pq) begin
      r = ~(c ^ {56'd0, ac_byte(COLW'(col + QOFS), rnd)});
    end else begin
      r = c ^ {ac_byte(col, rnd), 56'd0};
    end
    return r;
  endfunction

  logic [BCW-1:0]  bcnt;
  logic            pq_q;
  logic [RNDW-1:0] rnd_q;
  logic            m_valid_q;
  beat_t           out_q;

  logic            s_ready_int;
  logic            accept;
  logic            first_c;
  logic            last_c;
  logic            eff_pq;
  logic [RNDW-1:0] eff_rnd;
  beat_t           new_beat;

  assign accept = bus.s_valid && s_ready_int;

  // Transform of the beat currently offered on s_*; the first beat of a
  // state uses the live sideband, later beats use the latched copy.
  always_comb begin
    first_c  = (bcnt == '0);
    last_c   = (bcnt == BCNT_LAST);
    eff_pq   = first_c ? bus.s_pq  : pq_q;
    eff_rnd  = first_c ? bus.s_rnd : rnd_q;
    new_beat = '0;
    new_beat.pq    = eff_pq;
    new_beat.rnd   = eff_rnd;
    new_beat.first = first_c;
    new_beat.last  = last_c;
    for (int unsigned k = 0; k < LANES; k++) begin
      new_beat.data[DW-1-64*k -: 64] =
        ac_column(bus.s_data[DW-1-64*k -: 64],
                  COLW'(32'(bcnt) * LANES + k), eff_pq, eff_rnd);
    end
  end

  // Beat counter and per-state sideband latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt  <= '0;
      pq_q  <= 1'b0;
      rnd_q <= '0;
    end else if (accept) begin
      bcnt <= last_c ? '0 : bcnt + BCW'(1);
      if (first_c) begin
        pq_q  <= bus.s_pq;
        rnd_q <= bus.s_rnd;
      end
    end
  end

`ifdef GROSTL_AC_SKID_EN
  logic  skid_valid;
  beat_t skid_q;
  logic  s_ready_q;
  logic  out_free;

  assign out_free    = !m_valid_q || bus.m_ready;
  assign s_ready_int = s_ready_q;

  // Output register backed by a single skid entry; s_ready_q mirrors
  // "skid empty" so upstream never sees m_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      s_ready_q  <= 1'b1;
    end else if (skid_valid) begin
      if (out_free) begin
        out_q      <= skid_q;
        m_valid_q  <= 1'b1;
        skid_valid <= 1'b0;
        s_ready_q  <= 1'b1;
      end
    end else if (accept) begin
      if (out_free) begin
        out_q     <= new_beat;
        m_valid_q <= 1'b1;
      end else begin
        skid_q     <= new_beat;
        skid_valid <= 1'b1;
        s_ready_q  <= 1'b0;
      end
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end
`else
  assign s_ready_int = !m_valid_q || bus.m_ready;

  // Output register; an accept while draining reloads with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      out_q     <= '0;
    end else if (accept) begin
      out_q     <= new_beat;
      m_valid_q <= 1'b1;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end
`endif

  assign bus.s_ready = s_ready_int;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = out_q.data;
  assign bus.m_pq    = out_q.pq;
  assign bus.m_rnd   = out_q.rnd;
  assign bus.m_first = out_q.first;
  assign bus.m_last  = out_q.last;

endmodule

// File: tb/tb_grostl_add_constant_stream.sv
// Bench for grostl_add_constant_stream: an 8-column/1-lane instance and a
// 16-column/4-lane instance, driven from vector tables with a scoreboard.
`timescale 1ns/1ps
module tb_grostl_add_constant_stream;

  localparam int unsigned RNDW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  grostl_add_constant_stream_if #(.LANES(1), .RNDW(RNDW)) b8 ();
  grostl_add_constant_stream_if #(.LANES(4), .RNDW(RNDW)) b16 ();

  grostl_add_constant_stream #(.NCOLS(8), .LANES(1), .RNDW(RNDW), .Q_COL_OFS(6))
    u_dut8 (.clk(clk), .rst(rst), .bus(b8));
  grostl_add_constant_stream #(.NCOLS(16), .LANES(4), .RNDW(RNDW), .Q_COL_OFS(6))
    u_dut16 (.clk(clk), .rst(rst), .bus(b16));

  typedef struct {
    logic [63:0] data;
    logic        pq;
    logic [3:0]  rnd;
    logic [63:0] exp_data;
    logic        exp_pq;
    logic [3:0]  exp_rnd;
    logic        exp_first;
    logic        exp_last;
  } vec8_t;

  typedef struct {
    logic [255:0] data;
    logic         pq;
    logic [3:0]   rnd;
    logic [255:0] exp_data;
    logic         exp_pq;
    logic [3:0]   exp_rnd;
    logic         exp_first;
    logic         exp_last;
  } vec16_t;

  vec8_t  tbl8[$];
  vec16_t tbl16[$];
  vec8_t  sb8[$];
  vec16_t sb16[$];

  int checks = 0;
  int errors = 0;

  logic rforce8 = 1'b1;
  logic rrand16 = 1'b0;

  logic        prev_stall8 = 1'b0;
  logic [70:0] prev8;
  logic        prev_stall16 = 1'b0;
  logic [262:0] prev16;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: P adds {col,rnd} into byte 0; Q adds {(col+6)%n,rnd} into byte 7 then inverts.
  function automatic logic [63:0] model_col(input logic [63:0] d, input int col, input int ncols,
                                            input logic pq, input logic [3:0] rnd);
    logic [63:0] k;
    if (pq) begin
      k = 64'(((col + 6) % ncols) * 16 + int'(rnd));
      return ~(d ^ k);
    end
    k = 64'(col * 16 + int'(rnd)) << 56;
    return d ^ k;
  endfunction

  task automatic add_state8(input logic pq, input logic [3:0] rnd, input int tog, input bit zero);
    vec8_t v;
    for (int b = 0; b < 8; b++) begin
      v.data      = zero ? 64'd0 : {$urandom, $urandom};
      v.pq        = (b >= tog) ? ~pq : pq;
      v.rnd       = (b >= tog) ? 4'(rnd + 4'd5) : rnd;
      v.exp_data  = model_col(v.data, b, 8, pq, rnd);
      v.exp_pq    = pq;
      v.exp_rnd   = rnd;
      v.exp_first = (b == 0);
      v.exp_last  = (b == 7);
      tbl8.push_back(v);
    end
  endtask

  task automatic add_state16(input logic pq, input logic [3:0] rnd, input int tog, input bit zero);
    vec16_t v;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        v.data[255-64*k -: 64]     = zero ? 64'd0 : {$urandom, $urandom};
        v.exp_data[255-64*k -: 64] = model_col(v.data[255-64*k -: 64], b * 4 + k, 16, pq, rnd);
      end
      v.pq        = (b >= tog) ? ~pq : pq;
      v.rnd       = (b >= tog) ? 4'(rnd + 4'd3) : rnd;
      v.exp_pq    = pq;
      v.exp_rnd   = rnd;
      v.exp_first = (b == 0);
      v.exp_last  = (b == 3);
      tbl16.push_back(v);
    end
  endtask

  task automatic send8(input vec8_t v);
    bit done;
    done = 1'b0;
    b8.s_valid = 1'b1;
    b8.s_data  = v.data;
    b8.s_pq    = v.pq;
    b8.s_rnd   = v.rnd;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (b8.s_ready === 1'b1) begin
        sb8.push_back(v);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    b8.s_valid = 1'b0;
    chk("send8 accepted", 320'(done), 320'(1));
  endtask

  task automatic send16(input vec16_t v);
    bit done;
    done = 1'b0;
    b16.s_valid = 1'b1;
    b16.s_data  = v.data;
    b16.s_pq    = v.pq;
    b16.s_rnd   = v.rnd;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (b16.s_ready === 1'b1) begin
        sb16.push_back(v);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    b16.s_valid = 1'b0;
    chk("send16 accepted", 320'(done), 320'(1));
  endtask

  task automatic mon8();
    vec8_t e;
    logic [70:0] cur;
    cur = {b8.m_data, b8.m_pq, b8.m_rnd, b8.m_first, b8.m_last};
    if (rst) begin
      prev_stall8 = 1'b0;
      return;
    end
    if (prev_stall8) chk("hold8", 320'({b8.m_valid, cur}), 320'({1'b1, prev8}));
    if (b8.m_valid === 1'b1 && b8.m_ready === 1'b1) begin
      if (sb8.size() == 0) begin
        chk("out8 unexpected beat", 320'(cur), 320'(0));
      end else begin
        e = sb8.pop_front();
        chk("out8 beat", 320'(cur),
            320'({e.exp_data, e.exp_pq, e.exp_rnd, e.exp_first, e.exp_last}));
      end
    end
    prev_stall8 = (b8.m_valid === 1'b1) && (b8.m_ready !== 1'b1);
    prev8 = cur;
  endtask

  task automatic mon16();
    vec16_t e;
    logic [262:0] cur;
    cur = {b16.m_data, b16.m_pq, b16.m_rnd, b16.m_first, b16.m_last};
    if (rst) begin
      prev_stall16 = 1'b0;
      return;
    end
    if (prev_stall16) chk("hold16", 320'({b16.m_valid, cur}), 320'({1'b1, prev16}));
    if (b16.m_valid === 1'b1 && b16.m_ready === 1'b1) begin
      if (sb16.size() == 0) begin
        chk("out16 unexpected beat", 320'(cur), 320'(0));
      end else begin
        e = sb16.pop_front();
        chk("out16 beat", 320'(cur),
            320'({e.exp_data, e.exp_pq, e.exp_rnd, e.exp_first, e.exp_last}));
      end
    end
    prev_stall16 = (b16.m_valid === 1'b1) && (b16.m_ready !== 1'b1);
    prev16 = cur;
  endtask

  initial begin
    int nxt;
    rst         = 1'b1;
    b8.s_valid  = 1'b0;  b8.s_data  = '0; b8.s_pq  = 1'b0; b8.s_rnd  = '0; b8.m_ready  = 1'b1;
    b16.s_valid = 1'b0;  b16.s_data = '0; b16.s_pq = 1'b0; b16.s_rnd = '0; b16.m_ready = 1'b1;

    // 8-column states: rows 0..55
    add_state8(1'b0, 4'd3,  8, 1'b1);  // P zero, rnd 3
    add_state8(1'b1, 4'd3,  8, 1'b1);  // Q zero, rnd 3
    add_state8(1'b0, 4'd5,  3, 1'b0);  // P, sideband flips on beat 3
    add_state8(1'b1, 4'd15, 2, 1'b0);  // Q, sideband flips on beat 2
    add_state8(1'b0, 4'd7,  8, 1'b0);  // backpressure state
    add_state8(1'b1, 4'd2,  8, 1'b0);  // interrupted by reset
    add_state8(1'b0, 4'd1,  8, 1'b0);  // first state after reset
    tbl8[5].exp_data  = 64'h5300000000000000;
    tbl8[8].exp_data  = 64'hFFFFFFFFFFFFFF9C;
    tbl8[10].exp_data = 64'hFFFFFFFFFFFFFFFC;

    // 16-column, 4-lane states: rows 0..23
    add_state16(1'b0, 4'd13, 4, 1'b1);
    add_state16(1'b1, 4'd4,  4, 1'b0);
    add_state16(1'b0, 4'd11, 2, 1'b0);
    add_state16(1'b1, 4'd7,  1, 1'b0);
    add_state16(1'b0, 4'd2,  4, 1'b0);
    add_state16(1'b1, 4'd15, 3, 1'b0);
    tbl16[2].exp_data = {64'h8D00000000000000, 64'h9D00000000000000,
                         64'hAD00000000000000, 64'hBD00000000000000};

    fork
      forever begin
        @(negedge clk);
        mon8();
        mon16();
      end
      forever begin
        @(posedge clk);
        #1;
        b8.m_ready  = rforce8;
        b16.m_ready = rrand16 ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset dut8 outputs", 320'({b8.m_valid, b8.m_data, b8.m_pq, b8.m_rnd, b8.m_first, b8.m_last}), 320'(0));
    chk("reset dut16 outputs", 320'({b16.m_valid, b16.m_data, b16.m_pq, b16.m_rnd, b16.m_first, b16.m_last}), 320'(0));
    chk("reset dut8 s_ready", 320'(b8.s_ready), 320'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back states at full throughput.
    for (int i = 0; i < 32; i++) send8(tbl8[i]);

    // Backpressure mid-state: hold m_ready low for three cycles.
    for (int i = 32; i < 36; i++) send8(tbl8[i]);
    @(negedge clk);
    rforce8 = 1'b0;
    @(posedge clk);
    #1;
    send8(tbl8[36]);
`ifdef GROSTL_AC_SKID_EN
    send8(tbl8[37]);
    nxt = 38;
`else
    nxt = 37;
`endif
    b8.s_valid = 1'b1;
    b8.s_data  = tbl8[nxt].data;
    b8.s_pq    = tbl8[nxt].pq;
    b8.s_rnd   = tbl8[nxt].rnd;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall s_ready", 320'(b8.s_ready), 320'(0));
      if (i == 2) rforce8 = 1'b1;
      @(posedge clk);
      #1;
    end
    for (int i = nxt; i < 40; i++) send8(tbl8[i]);

    // Reset after beat 4 of a state; the partial state is discarded.
    for (int i = 40; i < 45; i++) send8(tbl8[i]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb8.delete();
    @(negedge clk);
    chk("rst mid m_valid", 320'(b8.m_valid), 320'(0));
    chk("rst mid m_first/m_data", 320'({b8.m_first, b8.m_data}), 320'(0));
    chk("rst mid s_ready", 320'(b8.s_ready), 320'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 48; i < 56; i++) send8(tbl8[i]);

    // Wide instance: steady ready, then random backpressure.
    for (int i = 0; i < 8; i++) send16(tbl16[i]);
    rrand16 = 1'b1;
    for (int i = 8; i < 24; i++) send16(tbl16[i]);

    for (int i = 0; i < 200 && (sb8.size() + sb16.size()) > 0; i++) @(posedge clk);
    rrand16 = 1'b0;
    chk("drain dut8 scoreboard", 320'(sb8.size()), 320'(0));
    chk("drain dut16 scoreboard", 320'(sb16.size()), 320'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
